// File: rtl/aclk_pkg.sv
// Shared definitions for the time-entry keypad block.
// Holds the special key codes, the FSM state encoding and the number of
// digits that make up a complete HH:MM entry.
package aclk_pkg;

  localparam logic [3:0] KEY_SET   = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StEntry = 2'd1;
  localparam state_t StLoad  = 2'd2;

endpackage

// File: rtl/aclk_time_entry_if.sv
// Keypad / time-load bus of the alarm-clock time-entry block.
//   key_valid, key_code, one_second       : keypad and 1 Hz tick (to entry block)
//   new_current_time_{ms,ls}_{hr,min}     : entered digits (from entry block)
//   load_new_c, entry_active, entry_error : status strobes (from entry block)
// master = keypad/timebase side, slave = entry block.
interface aclk_time_entry_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic       one_second;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic       load_new_c;
  logic       entry_active;
  logic       entry_error;

  modport master (
    output key_valid, key_code, one_second,
    input  new_current_time_ms_hr, new_current_time_ls_hr,
    input  new_current_time_ms_min, new_current_time_ls_min,
    input  load_new_c, entry_active, entry_error
  );

  modport slave (
    input  key_valid, key_code, one_second,
    output new_current_time_ms_hr, new_current_time_ls_hr,
    output new_current_time_ms_min, new_current_time_ls_min,
    output load_new_c, entry_active, entry_error
  );

endinterface

// File: rtl/aclk_time_valid.sv
// Combinational 24-hour time check on four BCD digits (HH:MM).
//   ms_hr_i, ls_hr_i, ms_min_i, ls_min_i : digits
//   valid_o                              : 1 when 00:00 <= time <= 23:59
module aclk_time_valid (
  input  logic [3:0] ms_hr_i,
  input  logic [3:0] ls_hr_i,
  input  logic [3:0] ms_min_i,
  input  logic [3:0] ls_min_i,
  output logic       valid_o
);

  logic hr_ok;

  always_comb begin
    hr_ok   = (ms_hr_i < 4'd2)  ? (ls_hr_i <= 4'd9) :
              (ms_hr_i == 4'd2) ? (ls_hr_i <= 4'd3) : 1'b0;
    valid_o = hr_ok && (ms_min_i <= 4'd5) && (ls_min_i <= 4'd9);
  end

endmodule

// File: rtl/aclk_time_entry.sv
// Keypad time entry for the alarm clock. Digits shift in from the right;
// SET with four digits forming a valid 24-hour time pulses load_new_c for one
// cycle, otherwise pulses entry_error. Entry aborts silently after
// TIMEOUT_SEC one_second ticks without an accepted key.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : keypad inputs, entered digits and status strobes (slave side)
module aclk_time_entry
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic              clk,
  input  logic              reset,
  aclk_time_entry_if.slave  bus
);

  localparam int unsigned TmoW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;

  state_t            state_q, state_d;
  logic [15:0]       dig_q, dig_d;   // {ms_hr, ls_hr, ms_min, ls_min}
  logic [2:0]        cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              time_valid;
  logic              is_digit;

  aclk_time_valid u_time_valid (
    .ms_hr_i  (dig_q[15:12]),
    .ls_hr_i  (dig_q[11:8]),
    .ms_min_i (dig_q[7:4]),
    .ls_min_i (dig_q[3:0]),
    .valid_o  (time_valid)
  );

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    is_digit = (bus.key_code <= 4'd9);

    case (state_q)
      StIdle: begin
        if (bus.key_valid && is_digit) begin
          dig_d   = {12'h000, bus.key_code};
          cnt_d   = 3'd1;
          tmo_d   = '0;
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (bus.key_valid && is_digit) begin
          dig_d = {dig_q[11:0], bus.key_code};
          if (cnt_q != 3'(NUM_DIGITS)) cnt_d = cnt_q + 3'd1;
          tmo_d = '0;
        end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
          dig_d = '0;
          cnt_d = '0;
          tmo_d = '0;
        end else if (bus.key_valid && bus.key_code == KEY_SET) begin
          tmo_d = '0;
          if (cnt_q == 3'(NUM_DIGITS) && time_valid) begin
            state_d = StLoad;
          end else begin
            err_d   = 1'b1;
            dig_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else if (bus.one_second) begin
          // Codes C-F fall through here, so they never restart the timeout.
          if (tmo_q == TmoW'(TIMEOUT_SEC - 1)) begin
            dig_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
      end
      StLoad: begin
        // Digits stay on the outputs until the next entry starts.
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dig_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign bus.new_current_time_ms_hr  = dig_q[15:12];
  assign bus.new_current_time_ls_hr  = dig_q[11:8];
  assign bus.new_current_time_ms_min = dig_q[7:4];
  assign bus.new_current_time_ls_min = dig_q[3:0];
  assign bus.load_new_c              = (state_q == StLoad);
  assign bus.entry_active            = (state_q == StEntry);
  assign bus.entry_error             = err_q;

endmodule

// File: tb/tb_aclk_time_entry.sv
module tb_aclk_time_entry;

  localparam int unsigned Tmo = 5;

  typedef struct packed {
    logic        is_err;
    logic [15:0] dig;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  aclk_time_entry_if bus ();

  aclk_time_entry #(
    .TIMEOUT_SEC (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired, got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] outs();
    return {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
            bus.new_current_time_ms_min, bus.new_current_time_ls_min};
  endfunction

  // Scoreboard: every load or error strobe must match the next expected event.
  always @(negedge clk) begin
    if (!reset && (bus.load_new_c || bus.entry_error)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got load=%0b err=%0b dig=%h, required no event",
                 bus.load_new_c, bus.entry_error, outs());
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.entry_error !== e.is_err || bus.load_new_c !== !e.is_err ||
            outs() !== e.dig) begin
          errors++;
          $display("FAIL sb_event: got err=%0b load=%0b dig=%h, required err=%0b load=%0b dig=%h",
                   bus.entry_error, bus.load_new_c, outs(), e.is_err, !e.is_err, e.dig);
        end
      end
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.one_second = 1'b1;
      @(negedge clk);
      bus.one_second = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic chk_status(input string name, input logic act, input logic [15:0] dig);
    chk({name, "_active"}, {15'd0, bus.entry_active}, {15'd0, act});
    chk({name, "_load"}, {15'd0, bus.load_new_c}, 16'd0);
    chk({name, "_digits"}, outs(), dig);
  endtask

  // Enter four keys and SET; checks the strobe in the cycle after SET.
  task automatic entry_set(input string name, input logic [3:0] k[4], input logic ok);
    logic [15:0] d;
    d = {k[0], k[1], k[2], k[3]};
    for (int i = 0; i < 4; i++) press(k[i]);
    exp_q.push_back('{is_err: !ok, dig: ok ? d : 16'h0000});
    press(aclk_pkg::KEY_SET);
    chk({name, "_load_after_set"}, {15'd0, bus.load_new_c}, {15'd0, ok});
    chk({name, "_err_after_set"}, {15'd0, bus.entry_error}, {15'd0, !ok});
    chk({name, "_dig_after_set"}, outs(), ok ? d : 16'h0000);
    @(negedge clk);
    chk_status({name, "_next"}, 1'b0, ok ? d : 16'h0000);
    chk({name, "_err_next"}, {15'd0, bus.entry_error}, 16'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.one_second = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_status("reset", 1'b0, 16'h0000);
    chk("reset_err", {15'd0, bus.entry_error}, 16'd0);
  endtask

  task automatic test_basic_load();
    entry_set("load1234", '{4'd1, 4'd2, 4'd3, 4'd4}, 1'b1);
    // IDLE ignores SET, CLEAR, C-F and ticks; digits stay held.
    press(aclk_pkg::KEY_SET);
    press(aclk_pkg::KEY_CLEAR);
    press(4'hC);
    tick(2);
    chk_status("idle_ignore", 1'b0, 16'h1234);
  endtask

  task automatic test_validity();
    entry_set("t2400", '{4'd2, 4'd4, 4'd0, 4'd0}, 1'b0);
    entry_set("t2359", '{4'd2, 4'd3, 4'd5, 4'd9}, 1'b1);
    entry_set("t1960", '{4'd1, 4'd9, 4'd6, 4'd0}, 1'b0);
    entry_set("t3000", '{4'd3, 4'd0, 4'd0, 4'd0}, 1'b0);
  endtask

  task automatic test_count_and_shift();
    press(4'd1);
    chk_status("first_digit", 1'b1, 16'h0001);
    press(4'd2);
    exp_q.push_back('{is_err: 1'b1, dig: 16'h0000});
    press(aclk_pkg::KEY_SET);
    chk("short_err", {15'd0, bus.entry_error}, 16'd1);
    chk_status("short", 1'b0, 16'h0000);
    press(4'd9);
    entry_set("shift", '{4'd1, 4'd2, 4'd3, 4'd4}, 1'b1);
  endtask

  task automatic test_clear();
    press(4'd1);
    press(4'd2);
    press(aclk_pkg::KEY_CLEAR);
    chk_status("clear", 1'b1, 16'h0000);
    entry_set("after_clear", '{4'd0, 4'd8, 4'd3, 4'd0}, 1'b1);
    // Three digits after CLEAR must not satisfy the count.
    press(4'd5);
    press(aclk_pkg::KEY_CLEAR);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    exp_q.push_back('{is_err: 1'b1, dig: 16'h0000});
    press(aclk_pkg::KEY_SET);
    chk("clear_count_err", {15'd0, bus.entry_error}, 16'd1);
  endtask

  task automatic test_timeout();
    press(4'd1);
    press(4'd2);
    tick(Tmo - 1);
    chk_status("tmo_before", 1'b1, 16'h0012);
    tick(1);
    chk_status("tmo_expired", 1'b0, 16'h0000);
    chk("tmo_err", {15'd0, bus.entry_error}, 16'd0);
    // Digit coincident with the final tick wins and restarts the count.
    press(4'd1);
    press(4'd2);
    tick(Tmo - 1);
    @(negedge clk);
    bus.key_valid  = 1'b1;
    bus.key_code   = 4'd3;
    bus.one_second = 1'b1;
    @(negedge clk);
    bus.key_valid  = 1'b0;
    bus.one_second = 1'b0;
    chk_status("tmo_key_wins", 1'b1, 16'h0123);
    tick(Tmo - 1);
    chk_status("tmo_restarted", 1'b1, 16'h0123);
    // Ignored code does not restart the count.
    press(4'hE);
    tick(1);
    chk_status("tmo_ignored_key", 1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) press(4'd1);
    exp_q.push_back('{is_err: 1'b0, dig: 16'h1111});
    press(aclk_pkg::KEY_SET);
    // Key during LOAD is dropped.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd7;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk_status("load_key_ignored", 1'b0, 16'h1111);
    entry_set("b2b", '{4'd0, 4'd0, 4'd0, 4'd0}, 1'b1);
  endtask

  task automatic test_reset_abort();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    #2 reset = 1'b1;
    #1;
    chk_status("rst_abort_async", 1'b0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_status("rst_abort", 1'b0, 16'h0000);
    chk("rst_abort_err", {15'd0, bus.entry_error}, 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_load();
    test_validity();
    test_count_and_shift();
    test_clear();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending events, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclk_time_entry.md
ACLK_TIME_ENTRY -- requirements
Module: aclk_time_entry

Interface
REQ-001 SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-002 SHALL have parameter TIMEOUT_SEC, default 10, number of one_second ticks without a key before entry aborts.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 key_valid  input  1  key_code qualified this cycle; single-cycle pulse per keypress.
REQ-006 key_code  input  4  0-9 = BCD digit, 4'hA = SET, 4'hB = CLEAR; 4'hC-4'hF ignored.
REQ-007 one_second  input  1  single-cycle tick, once per second.
REQ-008 new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min, new_current_time_ls_min  output  4 each  entered time digits, registered.
REQ-009 load_new_c  output  1  one-cycle pulse; new_current_time_* valid and held that cycle.
REQ-010 entry_active  output  1  high while in ENTRY.
REQ-011 entry_error  output  1  one-cycle pulse on rejected SET.

Function
REQ-012 SHALL implement FSM states IDLE, ENTRY, LOAD; load_new_c = (state==LOAD), entry_active = (state==ENTRY).
REQ-013 Digit shift SHALL be: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key_code; digit count increments, saturating at 4.
REQ-014 IDLE + digit: register cleared, then digit shifted in (result 0,0,0,d), count=1, go ENTRY.
REQ-015 IDLE + SET, CLEAR or ignored code: no state or register change.
REQ-016 ENTRY + digit: shift per REQ-013; a 5th+ digit keeps shifting with count held at 4.
REQ-017 ENTRY + CLEAR: digits and count zeroed, timeout counter zeroed, remain ENTRY.
REQ-018 ENTRY + SET with count==4 and valid time: go LOAD; load_new_c high exactly the cycle after SET is sampled.
REQ-019 Valid time SHALL mean ms_hr<=2; ls_hr<=9 (ls_hr<=3 when ms_hr==2); ms_min<=5; ls_min<=9; 23:59 valid, 24:00 invalid.
REQ-020 ENTRY + SET with count<4 or invalid time: entry_error high for the next cycle, digits and count zeroed, go IDLE, no load_new_c.
REQ-021 LOAD: lasts exactly one cycle, then IDLE; digits held until next entry; key_valid during LOAD ignored.
REQ-022 Timeout: in ENTRY, each one_second increments the timeout counter; any accepted key zeroes it; reaching TIMEOUT_SEC goes IDLE with digits and count zeroed, no load, no error.
REQ-023 key_valid and timeout-completing one_second in the same cycle: key SHALL win, timeout counter zeroed.
REQ-024 one_second outside ENTRY SHALL be ignored; timeout counter held at 0.
REQ-025 Keys with code 4'hC-4'hF SHALL change nothing, including timeout counter.

Reset
REQ-026 On reset: state IDLE; all new_current_time_* = 4'd0; load_new_c, entry_active, entry_error = 0; digit count and timeout counter = 0.
REQ-027 Reset asserted during ENTRY or LOAD SHALL abort with no load_new_c pulse, including the cycle reset deasserts.

Structure
REQ-028 Shared package aclk_pkg SHALL hold KEY_SET (4'hA), KEY_CLEAR (4'hB), FSM state type/encoding, and NUM_DIGITS (4).
REQ-029 Combinational sub-module aclk_time_valid SHALL take four BCD digits and return valid per REQ-019.

Verification
REQ-030 After reset, keys 1,2,3,4,SET -> load_new_c one cycle after SET, outputs 1,2,3,4; IDLE the next cycle.
REQ-031 Keys 2,4,0,0,SET -> entry_error one cycle, no load_new_c, outputs 0; also 2,3,5,9,SET -> load with 23:59.
REQ-032 Keys 1,2,SET -> entry_error (count<4); keys 9,1,2,3,4,SET -> load 12:34 (shift-out of first digit).
REQ-033 Keys 1,2 then TIMEOUT_SEC one_second ticks -> entry_active falls, outputs 0, no load; repeat with a digit coincident with the final tick -> stays ENTRY.
REQ-034 Keys 1,2,CLEAR,0,8,3,0,SET -> load 08:30; reset pulsed after 1,2,3 -> all outputs 0, IDLE, no load.
